anton_neopixel_stream_out: RTL and testbench

- Serialiser and encoder for the WS2812 (NeoPixel) line, clocked at 7 MHz.
- Takes the pixel byte buffer and the sequencing counters owned by the parent controller: byte index, bit index and sub-bit tick.
- Selects the current colour bit and turns it into the WS2812 high/low pulse pattern, eight ticks per bit, with a registered output.
- Holds no sequencing state of its own. The parent advances all counters.

---
 rtl/anton_neopixel_stream_out_if.sv | 58 +++++
 rtl/anton_neopixel_stream_out.sv | 127 ++++++++++++
 tb/tb_anton_neopixel_stream_out.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/anton_neopixel_stream_out_if.sv
// -----------------------------------------------------------------------------
// anton_neopixel_stream_out_if
//
// Purpose:
//   Signal bundle between the NeoPixel controller (master) and the stream
//   serialiser/encoder (slave).
//
// Handshake:
//   There is no valid/ready pair. Every signal is a plain level that the
//   slave samples on each rising edge of the stream clock. The master owns
//   all sequencing counters and may change any of them every cycle.
//
// Signals:
//   pixels            flattened byte buffer, byte n = pixels[8n+7:8n]
//   state             0 = transmit, 1 = reset/latch period
//   pixel_index       current byte index (pixel base address in 32-bit mode)
//   pixel_bit_index   bit within the 24-bit pixel, 0..23, 0 sent first
//   bit_pattern_index sub-bit tick, 0..7
//   reg_ctrl_32bit    1 = 32-bit pixel format, 0 = 8-bit RRRGGGBB format
//   reg_ctrl_run      streaming enable
//   neoData           registered WS2812 data line (slave output)
// -----------------------------------------------------------------------------
interface anton_neopixel_stream_out_if #(
   parameter int BUFFER_END = 31
);
   localparam int BUFFER_BITS = $clog2(BUFFER_END + 1);

   logic [8*(BUFFER_END+1)-1:0] pixels;
   logic                        state;
   logic [BUFFER_BITS-1:0]      pixel_index;
   logic [4:0]                  pixel_bit_index;
   logic [2:0]                  bit_pattern_index;
   logic                        reg_ctrl_32bit;
   logic                        reg_ctrl_run;
   logic                        neoData;

   modport master (
      output pixels,
      output state,
      output pixel_index,
      output pixel_bit_index,
      output bit_pattern_index,
      output reg_ctrl_32bit,
      output reg_ctrl_run,
      input  neoData
   );

   modport slave (
      input  pixels,
      input  state,
      input  pixel_index,
      input  pixel_bit_index,
      input  bit_pattern_index,
      input  reg_ctrl_32bit,
      input  reg_ctrl_run,
      output neoData
   );
endinterface

// File: rtl/anton_neopixel_stream_out.sv
// -----------------------------------------------------------------------------
// anton_neopixel_stream_out
//
// Purpose:
//   WS2812 (NeoPixel) serialiser and pulse encoder on the 7 MHz stream clock.
//   Picks the current colour bit out of the pixel buffer using the parent's
//   byte/bit/tick counters and turns it into the WS2812 high/low pattern
//   (eight ticks per bit). The output is registered, so it lags the inputs
//   by exactly one clock. No sequencing state lives here.
//
// Ports:
//   clk7mhz  7 MHz stream clock
//   resetn   asynchronous, active-low reset
//   bus      anton_neopixel_stream_out_if.slave (buffer, counters, control,
//            neoData output)
//
// Parameters:
//   BUFFER_END  last byte index of the pixel buffer (must match the interface)
//
// Build options:
//   ANTON_NEOPIXEL_STREAM_INVERT_EN  when defined, neoData is inverted for
//   inverting level shifters; idle and reset level become 1.
// -----------------------------------------------------------------------------
module anton_neopixel_stream_out #(
   parameter int BUFFER_END = 31
) (
   input logic                        clk7mhz,
   input logic                        resetn,
   anton_neopixel_stream_out_if.slave bus
);

   localparam int BUFFER_BITS = $clog2(BUFFER_END + 1);
   // One extra address bit so pixel_index+2 cannot wrap back into the buffer.
   localparam int AW = BUFFER_BITS + 1;
   localparam logic [AW-1:0] END_ADDR = AW'(BUFFER_END);

   localparam logic ENUM_STATE_TRANSMIT = 1'b0;

`ifdef ANTON_NEOPIXEL_STREAM_INVERT_EN
   localparam logic INVERT = 1'b1;
`else
   localparam logic INVERT = 1'b0;
`endif

   // Byte view of the flattened buffer.
   logic [7:0] buf_bytes [0:BUFFER_END];

   for (genvar gi = 0; gi <= BUFFER_END; gi++) begin : g_bytes
      assign buf_bytes[gi] = bus.pixels[8*gi +: 8];
   end

   // Addresses beyond the buffer read as zero rather than wrapping.
   function automatic logic [7:0] fetch(input logic [AW-1:0] addr);
      if (addr > END_ADDR) begin
         return 8'h00;
      end
      return buf_bytes[addr[BUFFER_BITS-1:0]];
   endfunction

   logic [AW-1:0] addr_base;
   logic [AW-1:0] addr_g;
   logic [AW-1:0] addr_b;

   assign addr_base = {1'b0, bus.pixel_index};
   assign addr_g    = addr_base + AW'(1);
   assign addr_b    = addr_base + AW'(2);

   logic [7:0] byte8;
   logic [7:0] chan_r;
   logic [7:0] chan_g;
   logic [7:0] chan_b;
   logic [7:0] chan_sel;
   logic       bitval;
   logic       active;
   logic       pulse_high;
   logic       neo_q;

   assign byte8 = fetch(addr_base);

   always_comb begin
      chan_r = 8'h00;
      chan_g = 8'h00;
      chan_b = 8'h00;
      if (bus.reg_ctrl_32bit) begin
         chan_r = byte8;
         chan_g = fetch(addr_g);
         chan_b = fetch(addr_b);
      end else begin
         // RRRGGGBB expanded by bit replication so full-scale stays 0xFF.
         chan_r = {byte8[7:5], byte8[7:5], byte8[7:6]};
         chan_g = {byte8[4:2], byte8[4:2], byte8[4:3]};
         chan_b = {byte8[1:0], byte8[1:0], byte8[1:0], byte8[1:0]};
      end
   end

   // Wire order is G, R, B; bit indices 24..31 select nothing.
   always_comb begin
      chan_sel = 8'h00;
      case (bus.pixel_bit_index[4:3])
         2'd0:    chan_sel = chan_g;
         2'd1:    chan_sel = chan_r;
         2'd2:    chan_sel = chan_b;
         default: chan_sel = 8'h00;
      endcase
   end

   // MSB first: position 7 - i, which for a 3-bit i is simply ~i.
   assign bitval = chan_sel[~bus.pixel_bit_index[2:0]];

   assign active = bus.reg_ctrl_run && (bus.state == ENUM_STATE_TRANSMIT);

   // 0-bit: 2 ticks high / 6 low; 1-bit: 5 ticks high / 3 low.
   assign pulse_high = active &&
                       (bitval ? (bus.bit_pattern_index < 3'd5)
                               : (bus.bit_pattern_index < 3'd2));

   always_ff @(posedge clk7mhz or negedge resetn) begin
      if (!resetn) begin
         neo_q <= INVERT;
      end else begin
         neo_q <= pulse_high ^ INVERT;
      end
   end

   assign bus.neoData = neo_q;

endmodule

// File: tb/tb_anton_neopixel_stream_out.sv
// -----------------------------------------------------------------------------
// tb_anton_neopixel_stream_out
//
// Directed bench for the WS2812 stream encoder. Expected levels are written in
// terms of hand-computed colour bit streams and the 2/6 and 5/3 tick patterns.
// -----------------------------------------------------------------------------
module tb_anton_neopixel_stream_out;

   localparam int BUFFER_END = 31;

`ifdef ANTON_NEOPIXEL_STREAM_INVERT_EN
   localparam logic INV = 1'b1;
`else
   localparam logic INV = 1'b0;
`endif

   logic clk7mhz;
   logic resetn;

   anton_neopixel_stream_out_if #(.BUFFER_END(BUFFER_END)) bus ();

   anton_neopixel_stream_out #(.BUFFER_END(BUFFER_END)) dut (
      .clk7mhz (clk7mhz),
      .resetn  (resetn),
      .bus     (bus.slave)
   );

   // ---------------- clock ----------------
   initial begin
      clk7mhz = 1'b0;
      forever #71 clk7mhz = ~clk7mhz;
   end

   // ---------------- scoreboard ----------------
   int   n_checks = 0;
   int   n_errors = 0;
   logic last_exp;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // exp_hi is the un-inverted line level; the bench applies polarity here.
   task automatic expect_out(input string tag, input logic exp_hi);
      check(tag, {31'd0, bus.neoData}, {31'd0, exp_hi ^ INV});
      last_exp = exp_hi;
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_byte(input int n, input logic [7:0] v);
      bus.pixels[8*n +: 8] = v;
   endtask

   task automatic fill_all(input logic [7:0] v);
      for (int n = 0; n <= BUFFER_END; n++) bus.pixels[8*n +: 8] = v;
   endtask

   // Called just after a rising edge: apply one tick, confirm the output has
   // not moved yet, then confirm it one edge later.
   task automatic send_tick(input string tag, input logic [4:0] bi,
                            input logic [2:0] pi, input logic exp_hi);
      bus.pixel_bit_index   = bi;
      bus.bit_pattern_index = pi;
      #1;
      check({tag, "_hold"}, {31'd0, bus.neoData}, {31'd0, last_exp ^ INV});
      @(posedge clk7mhz);
      #1;
      expect_out(tag, exp_hi);
   endtask

   // Full eight-tick waveform for one bit.
   task automatic send_bit(input string tag, input logic [4:0] bi, input logic b);
      for (int p = 0; p < 8; p++) begin
         send_tick($sformatf("%s_b%0d_t%0d", tag, bi, p), bi, 3'(p),
                   b ? (p < 5) : (p < 2));
      end
   endtask

   // ---------------- stimulus ----------------
   logic [23:0] stream;

   initial begin
      last_exp              = 1'b0;
      resetn                = 1'b0;
      bus.pixels            = '0;
      bus.state             = 1'b0;
      bus.pixel_index       = '0;
      bus.pixel_bit_index   = 5'd0;
      bus.bit_pattern_index = 3'd0;
      bus.reg_ctrl_32bit    = 1'b0;
      bus.reg_ctrl_run      = 1'b1;
      set_byte(0, 8'hFF);

      // Reset held while active with a 1-bit at tick 0: line stays idle.
      #5;
      expect_out("reset_async", 1'b0);
      repeat (3) @(posedge clk7mhz);
      #1;
      expect_out("reset_held", 1'b0);
      resetn = 1'b1;
      #1;
      expect_out("reset_release_noedge", 1'b0);
      @(posedge clk7mhz);
      #1;
      expect_out("reset_first_pattern", 1'b1);

      // 8-bit mode, 0x1C -> green 0xFF, red 0x00, blue 0x00.
      set_byte(0, 8'h1C);
      for (int b = 0; b < 24; b++) send_bit("m8_green", 5'(b), b < 8);

      // 8-bit expansion of 0x4D: G=0x6D, R=0x49, B=0x55, checked at tick 2
      // where a 1-bit is high and a 0-bit is low.
      set_byte(3, 8'h4D);
      bus.pixel_index = 5'd3;
      stream = 24'h6D4955;
      for (int b = 0; b < 24; b++)
         send_tick($sformatf("m8_expand_b%0d", b), 5'(b), 3'd2, stream[23-b]);

      // 32-bit mode at base 4: R=0x80, G=0x01, B=0xAA, spare 0xFF ignored.
      bus.reg_ctrl_run   = 1'b0;
      bus.reg_ctrl_32bit = 1'b1;
      send_tick("m32_mode_switch", 5'd0, 3'd0, 1'b0);
      bus.reg_ctrl_run = 1'b1;
      set_byte(4, 8'h80);
      set_byte(5, 8'h01);
      set_byte(6, 8'hAA);
      set_byte(7, 8'hFF);
      bus.pixel_index = 5'd4;
      stream = 24'h0180AA;
      for (int b = 0; b < 24; b++) send_bit("m32", 5'(b), stream[23-b]);

      // Base 30: green/red in range (0xFF), blue address 32 reads as 0x00.
      fill_all(8'hFF);
      bus.pixel_index = 5'd30;
      for (int b = 0; b < 16; b++)
         send_tick($sformatf("m32_edge_b%0d", b), 5'(b), 3'd2, 1'b1);
      for (int b = 16; b < 24; b++) send_bit("m32_edge_blue", 5'(b), 1'b0);

      // Invalid bit indices 24..31 carry a 0-bit (low at tick 3).
      bus.reg_ctrl_32bit = 1'b0;
      bus.pixel_index    = 5'd0;
      for (int b = 24; b < 32; b++)
         send_tick($sformatf("invalid_b%0d", b), 5'(b), 3'd3, 1'b0);

      // Latch period: state = reset, buffer all 0xFF.
      bus.state = 1'b1;
      for (int c = 0; c < 200; c++)
         send_tick($sformatf("idle_state_c%0d", c), 5'(c % 24), 3'(c % 8), 1'b0);
      // Run deasserted while transmitting.
      bus.state        = 1'b0;
      bus.reg_ctrl_run = 1'b0;
      for (int c = 0; c < 200; c++)
         send_tick($sformatf("idle_run_c%0d", c), 5'(c % 24), 3'(c % 8), 1'b0);

      // Reset mid-operation: line drops at once, resumes one edge after release.
      bus.reg_ctrl_run = 1'b1;
      send_tick("midrst_pre", 5'd0, 3'd0, 1'b1);
      #20;
      resetn = 1'b0;
      #1;
      expect_out("midrst_async", 1'b0);
      @(posedge clk7mhz);
      #1;
      expect_out("midrst_held", 1'b0);
      resetn = 1'b1;
      bus.bit_pattern_index = 3'd4;
      #1;
      expect_out("midrst_release_noedge", 1'b0);
      @(posedge clk7mhz);
      #1;
      expect_out("midrst_resume", 1'b1);
      send_tick("midrst_tick5", 5'd0, 3'd5, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
